// File: rtl/rvm_constants.sv
// Shared constants for the RVM execute path: bitwise op codes and the
// operand-fetch state encodings.
package rvm_constants;

  localparam logic [2:0] RVM_BITWISE_NOP = 3'b000;
  localparam logic [2:0] RVM_BITWISE_OR  = 3'b001;
  localparam logic [2:0] RVM_BITWISE_AND = 3'b010;
  localparam logic [2:0] RVM_BITWISE_XOR = 3'b011;

  typedef enum logic [2:0] {
    RVM_OPF_IDLE = 3'd0,
    RVM_OPF_RD1  = 3'd1,
    RVM_OPF_RD2  = 3'd2,
    RVM_OPF_CAP2 = 3'd3,
    RVM_OPF_OUT  = 3'd4
  } rvm_opf_state_e;

endpackage

// File: rtl/rvm_operand_fetch.sv
// Operand fetch: sequences rs1/rs2 reads through the single register file
// read port, substitutes the immediate, and presents registered operands.
module rvm_operand_fetch
  import rvm_constants::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [RA_W-1:0] dec_rs1,
  input  logic [RA_W-1:0] dec_rs2,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            dec_use_imm,
  input  logic [2:0]      dec_op,
  output logic            rf_rd_en,
  output logic [RA_W-1:0] rf_rd_addr,
  input  logic [XLEN-1:0] rf_rd_data,
  output logic            exe_valid,
  input  logic            exe_ready,
  output logic [XLEN-1:0] lhs,
  output logic [XLEN-1:0] rhs,
  output logic [2:0]      op
);

  rvm_opf_state_e  state_q, state_d;
  logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            use_imm_q, use_imm_d;
  logic [2:0]      op_cap_q, op_cap_d;
  logic [XLEN-1:0] lhs_q, lhs_d, rhs_q, rhs_d;
  logic            exe_valid_q, exe_valid_d;
  logic [2:0]      op_q, op_d;
  logic            rf_rd_en_q, rf_rd_en_d;
  logic [RA_W-1:0] rf_rd_addr_q, rf_rd_addr_d;

  // Next-state and next-output computation; read strobes are one-cycle pulses.
  always_comb begin
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    imm_d        = imm_q;
    use_imm_d    = use_imm_q;
    op_cap_d     = op_cap_q;
    lhs_d        = lhs_q;
    rhs_d        = rhs_q;
    exe_valid_d  = exe_valid_q;
    op_d         = op_q;
    rf_rd_en_d   = 1'b0;
    rf_rd_addr_d = {RA_W{1'b0}};
    case (state_q)
      RVM_OPF_IDLE: begin
        if (dec_valid) begin
          rs1_d        = dec_rs1;
          rs2_d        = dec_rs2;
          imm_d        = dec_imm;
          use_imm_d    = dec_use_imm;
          op_cap_d     = dec_op;
          rf_rd_en_d   = (dec_rs1 != {RA_W{1'b0}});
          rf_rd_addr_d = dec_rs1;
          state_d      = RVM_OPF_RD1;
        end else begin
          state_d = RVM_OPF_IDLE;
        end
      end
      RVM_OPF_RD1: begin
        if (!use_imm_q) begin
          rf_rd_en_d   = (rs2_q != {RA_W{1'b0}});
          rf_rd_addr_d = rs2_q;
        end else begin
          rf_rd_en_d   = 1'b0;
          rf_rd_addr_d = {RA_W{1'b0}};
        end
        state_d = RVM_OPF_RD2;
      end
      RVM_OPF_RD2: begin
        lhs_d = (rs1_q == {RA_W{1'b0}}) ? {XLEN{1'b0}} : rf_rd_data;
        if (use_imm_q) begin
          rhs_d       = imm_q;
          exe_valid_d = 1'b1;
          op_d        = op_cap_q;
          state_d     = RVM_OPF_OUT;
        end else begin
          state_d = RVM_OPF_CAP2;
        end
      end
      RVM_OPF_CAP2: begin
        rhs_d       = (rs2_q == {RA_W{1'b0}}) ? {XLEN{1'b0}} : rf_rd_data;
        exe_valid_d = 1'b1;
        op_d        = op_cap_q;
        state_d     = RVM_OPF_OUT;
      end
      RVM_OPF_OUT: begin
        if (exe_ready) begin
          exe_valid_d = 1'b0;
          op_d        = RVM_BITWISE_NOP;
          state_d     = RVM_OPF_IDLE;
        end else begin
          state_d = RVM_OPF_OUT;
        end
      end
      default: begin
        exe_valid_d = 1'b0;
        op_d        = RVM_BITWISE_NOP;
        state_d     = RVM_OPF_IDLE;
      end
    endcase
    // Flush discards the in-flight instruction and returns everything to reset values.
    if (flush) begin
      state_d      = RVM_OPF_IDLE;
      rs1_d        = {RA_W{1'b0}};
      rs2_d        = {RA_W{1'b0}};
      imm_d        = {XLEN{1'b0}};
      use_imm_d    = 1'b0;
      op_cap_d     = RVM_BITWISE_NOP;
      lhs_d        = {XLEN{1'b0}};
      rhs_d        = {XLEN{1'b0}};
      exe_valid_d  = 1'b0;
      op_d         = RVM_BITWISE_NOP;
      rf_rd_en_d   = 1'b0;
      rf_rd_addr_d = {RA_W{1'b0}};
    end else begin
      state_d = state_d;
    end
  end

  // State and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RVM_OPF_IDLE;
      rs1_q        <= {RA_W{1'b0}};
      rs2_q        <= {RA_W{1'b0}};
      imm_q        <= {XLEN{1'b0}};
      use_imm_q    <= 1'b0;
      op_cap_q     <= RVM_BITWISE_NOP;
      lhs_q        <= {XLEN{1'b0}};
      rhs_q        <= {XLEN{1'b0}};
      exe_valid_q  <= 1'b0;
      op_q         <= RVM_BITWISE_NOP;
      rf_rd_en_q   <= 1'b0;
      rf_rd_addr_q <= {RA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_q        <= imm_d;
      use_imm_q    <= use_imm_d;
      op_cap_q     <= op_cap_d;
      lhs_q        <= lhs_d;
      rhs_q        <= rhs_d;
      exe_valid_q  <= exe_valid_d;
      op_q         <= op_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
    end
  end

  assign dec_ready  = (state_q == RVM_OPF_IDLE);
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign exe_valid  = exe_valid_q;
  assign lhs        = lhs_q;
  assign rhs        = rhs_q;
  assign op         = op_q;

endmodule

// File: doc/rvm_operand_fetch.md
Name: rvm_operand_fetch

Overview:
Upstream stage feeding the bitwise unit (and sibling ALU units) of the multi-cycle RISC-V core. Accepts one decoded instruction, reads rs1/rs2 through the single read port of the register file over successive cycles, and substitutes the immediate when required. Presents registered lhs/rhs/op to execute under a valid/ready handshake. op is held at NOP whenever no operand pair is presented, so the downstream unit stays isolated and reports not-valid.

Parameters:
XLEN, 32, operand/data width
RA_W, 5, register address width

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort; discard the in-flight instruction
dec_valid  in  1  decoded instruction available
dec_ready  out  1  stage can accept (IDLE only)
dec_rs1  in  RA_W  source register 1 address
dec_rs2  in  RA_W  source register 2 address
dec_imm  in  XLEN  sign-extended immediate
dec_use_imm  in  1  rhs = immediate instead of rs2
dec_op  in  3  bitwise op code (RVM_BITWISE_*)
rf_rd_en  out  1  register file read strobe
rf_rd_addr  out  RA_W  register file read address
rf_rd_data  in  XLEN  read data, valid the cycle after rf_rd_en
exe_valid  out  1  lhs/rhs/op valid
exe_ready  in  1  execute consumes this cycle
lhs  out  XLEN  left operand
rhs  out  XLEN  right operand
op  out  3  op code to the bitwise unit

Behaviour:
- Reset (async) and flush (sync, highest priority after reset): state=IDLE; lhs=rhs=0; op=NOP(3'b000); exe_valid=0; rf_rd_en=0; rf_rd_addr=0; all captured fields cleared. Reset mid-operation discards the instruction and issues no further reads.
- States: IDLE, RD1, RD2, CAP2, OUT. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs except dec_ready = (state==IDLE).
- IDLE: on dec_valid, capture rs1, rs2, imm, use_imm and op, then go to RD1. Any other input is ignored.
- RD1: rf_rd_en = (rs1!=0), rf_rd_addr = rs1. Go to RD2.
- RD2: lhs_q <= (rs1==0) ? 0 : rf_rd_data.
  - If use_imm: rhs_q <= imm and go to OUT.
  - Else: rf_rd_en = (rs2!=0), rf_rd_addr = rs2, and go to CAP2.
- CAP2: rhs_q <= (rs2==0) ? 0 : rf_rd_data. Go to OUT.
- OUT: exe_valid=1 and op=op_q; lhs/rhs hold stable. On exe_ready go to IDLE, and op returns to NOP the following cycle.
  - A new instruction is accepted only after the return to IDLE; there is no back-to-back overlap.
- Outside OUT: op=NOP and exe_valid=0. lhs/rhs may hold stale values but are don't-care.
- Latency from the dec_valid acceptance edge to exe_valid: 3 cycles with an immediate, 4 cycles register-register.
- Stall: exe_ready low holds OUT indefinitely, with no rereads of the register file.
- x0: no read strobe is issued for it, and the operand is forced to 0 regardless of rf_rd_data.
- rs1==rs2: two reads are still performed, so sequencing is uniform.
- dec_op==NOP: the instruction is still sequenced. exe_valid=1 is presented with op=NOP; the downstream unit returns valid=0 and the stage completes on exe_ready.

Decomposition:
- The shared constants file (rvm_constants) holds:
  - RVM_BITWISE_NOP/OR/AND/XOR
  - new state encodings RVM_OPF_IDLE/RD1/RD2/CAP2/OUT (3-bit)
- The block is a single module with no sub-module; the FSM and operand registers are one unit.

Test Plan:
- use_imm: rs1=3 (RF[3]=0x0000_F0F0), imm=0x0000_0FF0, op=OR, exe_ready=1 -> rf reads addr 3 only; exe_valid is high 3 cycles after acceptance with lhs=0x0000F0F0, rhs=0x00000FF0, op=01; the bitwise unit yields 0x0000FFF0.
- Reg-reg: rs1=1, rs2=2 (RF=0xFFFF0000, 0x0F0F0F0F), op=XOR -> reads at addr 1 then addr 2 on consecutive cycles; exe_valid after 4 cycles; lhs=0xFFFF0000, rhs=0x0F0F0F0F.
- x0: rs1=0, rs2=5, with rf_rd_data driven to 0xDEADBEEF -> rf_rd_en is never high for addr 0; lhs=0, rhs=RF[5]; rf_rd_en is high for exactly one cycle.
- Backpressure: exe_ready=0 for 5 cycles in OUT -> exe_valid, lhs, rhs and op are stable and dec_ready=0 throughout; at exe_ready=1, IDLE follows, then op=NOP and dec_ready=1.
- Flush in CAP2 -> next cycle IDLE, exe_valid never asserts, op=NOP; a subsequent instruction is processed normally.
- Async reset asserted mid-RD2 (between clock edges) -> outputs are zero/NOP immediately; after deassertion, dec_ready=1.
